// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry, game FSM state encodings and coordinate type.
// Also holds the platform x generator used by the scroll controller.
package game_pkg;
    localparam int         SCREEN_H  = 480;
    localparam int         X_MAX     = 600;
    localparam logic [9:0] LFSR_SEED = 10'h2A5;

    typedef logic [9:0] coord_t;

    typedef enum logic [2:0] {
        GS_MENU    = 3'b000,
        GS_GAME    = 3'b001,
        GS_PAUSE   = 3'b010,
        GS_REFRESH = 3'b011
    } game_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SWEEP
    } scroll_state_t;

    // Single conditional subtract is enough because the LFSR range is below 2*xmax.
    function automatic coord_t xgen(input coord_t v, input coord_t xmax);
        return (v >= xmax) ? v - xmax : v;
    endfunction
endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR (taps 10,7), advancing only when i_adv is high.
module lfsr10 #(
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adv,
    output logic [9:0] o_q
);
    logic [9:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= SEED;
        else if (i_adv)
            r_q <= {r_q[8:0], r_q[9] ^ r_q[6]};
    end

    assign o_q = r_q;
endmodule

// File: rtl/platform_scroll_ctrl.sv
// Platform register-file sequencer: seeds platforms on game start and scrolls them
// down one STEP per qualifying frame, respawning platforms that fall off the bottom.
module platform_scroll_ctrl #(
    parameter int NUM_PLAT    = 8,
    parameter int Y_W         = 10,
    parameter int SCREEN_H    = game_pkg::SCREEN_H,
    parameter int X_MAX       = game_pkg::X_MAX,
    parameter int SCROLL_LINE = 160,
    parameter int STEP        = 4,
    localparam int IW         = $clog2(NUM_PLAT)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_frame_tick,
    input  logic [2:0]     i_outstate,
    input  logic           i_loadplat,
    input  logic [Y_W-1:0] i_doodle_y,
    output logic [IW-1:0]  o_plat_idx,
    input  logic [Y_W-1:0] i_plat_rd_x,
    input  logic [Y_W-1:0] i_plat_rd_y,
    output logic           o_plat_we,
    output logic [Y_W-1:0] o_plat_wr_x,
    output logic [Y_W-1:0] o_plat_wr_y,
    output logic           o_refresh_en,
    output logic           o_doodle_shift,
    output logic [15:0]    o_scroll_total,
    output logic           o_busy
);
    import game_pkg::*;

    localparam int ROW_GAP = SCREEN_H / NUM_PLAT;

    scroll_state_t  r_state, w_next;
    logic [IW-1:0]  r_idx;
    logic [15:0]    r_total;
    logic           r_shift;
    logic [9:0]     w_lfsr;
    logic           w_lfsr_adv;
    logic [Y_W-1:0] w_xgen;
    logic [Y_W:0]   w_ny;
    logic           w_respawn;
    logic           w_last;
    logic           w_start_sweep;
    logic [16:0]    w_sum;

    lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_adv (w_lfsr_adv),
        .o_q   (w_lfsr)
    );

    assign w_xgen        = Y_W'(xgen(w_lfsr, coord_t'(X_MAX)));
    assign w_last        = (r_idx == IW'(NUM_PLAT - 1));
    assign w_start_sweep = i_frame_tick && (i_outstate == GS_GAME) &&
                           (i_doodle_y < Y_W'(SCROLL_LINE));
    assign w_sum         = {1'b0, r_total} + 17'(STEP);

    always_comb begin
        w_next      = r_state;
        o_plat_we   = 1'b0;
        o_plat_wr_x = '0;
        o_plat_wr_y = '0;
        w_lfsr_adv  = 1'b0;
        w_ny        = {1'b0, i_plat_rd_y} + (Y_W+1)'(STEP);
        w_respawn   = (w_ny >= (Y_W+1)'(SCREEN_H));
        case (r_state)
            S_IDLE: begin
                if (i_loadplat)
                    w_next = S_INIT;
                else if (w_start_sweep)
                    w_next = S_SWEEP;
            end
            S_INIT: begin
                o_plat_we   = 1'b1;
                o_plat_wr_x = w_xgen;
                o_plat_wr_y = Y_W'(int'(r_idx) * ROW_GAP);
                w_lfsr_adv  = 1'b1;
                if (w_last)
                    w_next = S_IDLE;
            end
            S_SWEEP: begin
                o_plat_we = 1'b1;
                if (w_respawn) begin
                    o_plat_wr_x = w_xgen;
                    o_plat_wr_y = Y_W'(w_ny - (Y_W+1)'(SCREEN_H));
                    w_lfsr_adv  = 1'b1;
                end else begin
                    o_plat_wr_x = i_plat_rd_x;
                    o_plat_wr_y = w_ny[Y_W-1:0];
                end
                if (w_last)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Index is parked at 0 in IDLE so every sequence starts from platform 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_total <= '0;
            r_shift <= 1'b0;
        end else begin
            r_shift <= (r_state == S_IDLE) && !i_loadplat && w_start_sweep;
            if (r_state == S_IDLE) begin
                r_idx <= '0;
                if (i_loadplat)
                    r_total <= '0;
                else if (w_start_sweep)
                    r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            end else begin
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            end
        end
    end

    assign o_plat_idx     = r_idx;
    assign o_refresh_en   = (r_state == S_SWEEP);
    assign o_busy         = (r_state != S_IDLE);
    assign o_doodle_shift = r_shift;
    assign o_scroll_total = r_total;
endmodule

// File: tb/tb_platform_scroll_ctrl.sv
// Directed bench for platform_scroll_ctrl: seeding, scrolling, respawn, dropped ticks,
// mid-sweep reset and score saturation (on a large-STEP instance to keep runtime short).
module tb_platform_scroll_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       tick, loadplat;
    logic [2:0] outstate;
    logic [9:0] doodle_y;
    logic [2:0] idx;
    logic [9:0] rd_x, rd_y, wr_x, wr_y;
    logic       we, refresh, shift, busy;
    logic [15:0] total;

    logic        s_tick, s_load;
    logic [2:0]  s_idx;
    logic [9:0]  s_wr_x, s_wr_y;
    logic        s_we, s_refresh, s_shift, s_busy;
    logic [15:0] s_total;

    logic [9:0] rf_x [8];
    logic [9:0] rf_y [8];
    logic       bd_en;
    logic [2:0] bd_idx;
    logic [9:0] bd_y;

    int vectors = 0;
    int errs    = 0;
    int exp_total = 0;
    int resp_q[$];
    int INIT_X[8] = '{77, 331, 63, 303, 6, 188, 376, 153};

    always #5 clk = ~clk;

    platform_scroll_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_outstate(outstate),
        .i_loadplat(loadplat), .i_doodle_y(doodle_y), .o_plat_idx(idx),
        .i_plat_rd_x(rd_x), .i_plat_rd_y(rd_y), .o_plat_we(we),
        .o_plat_wr_x(wr_x), .o_plat_wr_y(wr_y), .o_refresh_en(refresh),
        .o_doodle_shift(shift), .o_scroll_total(total), .o_busy(busy)
    );

    platform_scroll_ctrl #(.STEP(1000)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(s_tick), .i_outstate(3'b001),
        .i_loadplat(s_load), .i_doodle_y(10'd0), .o_plat_idx(s_idx),
        .i_plat_rd_x(10'd0), .i_plat_rd_y(10'd0), .o_plat_we(s_we),
        .o_plat_wr_x(s_wr_x), .o_plat_wr_y(s_wr_y), .o_refresh_en(s_refresh),
        .o_doodle_shift(s_shift), .o_scroll_total(s_total), .o_busy(s_busy)
    );

    // Platform register file the controller drives; backdoor port plants test positions.
    assign rd_x = rf_x[idx];
    assign rd_y = rf_y[idx];
    always @(posedge clk) begin
        if (we) begin
            rf_x[idx] <= wr_x;
            rf_y[idx] <= wr_y;
        end else if (bd_en) begin
            rf_y[bd_idx] <= bd_y;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_init();
        int n = 0;
        loadplat = 1'b1;
        step();
        loadplat = 1'b0;
        while (busy && n < 20) begin
            if (n < 8) begin
                chk("init_we", 32'(we), 1);
                chk("init_idx", 32'(idx), n);
                chk("init_y", 32'(wr_y), n * 60);
                chk("init_x", 32'(wr_x), INIT_X[n]);
            end
            step();
            n++;
        end
        chk("init_len", n, 8);
        chk("init_idle_we", 32'(we), 0);
        chk("init_idle_idx", 32'(idx), 0);
        chk("init_total_clr", 32'(total), 0);
        for (int i = 0; i < 8; i++) chk("init_rf_y", 32'(rf_y[i]), i * 60);
    endtask

    task automatic sweep(input int tick_at);
        int n = 0;
        int ny;
        logic [9:0] ex_x [8];
        logic [9:0] ex_y [8];
        for (int i = 0; i < 8; i++) begin
            ny = int'(rf_y[i]) + 4;
            if (ny >= 480) begin
                ex_y[i] = 10'(ny - 480);
                ex_x[i] = 10'(resp_q.pop_front());
            end else begin
                ex_y[i] = 10'(ny);
                ex_x[i] = rf_x[i];
            end
        end
        exp_total += 4;
        outstate = 3'b001;
        doodle_y = 10'd100;
        tick = 1'b1;
        chk("pre_refresh", 32'(refresh), 0);
        step();
        tick = 1'b0;
        chk("shift_pulse", 32'(shift), 1);
        chk("sweep_total", 32'(total), exp_total);
        while (refresh && n < 20) begin
            if (n == 1) chk("shift_once", 32'(shift), 0);
            if (n < 8) begin
                chk("sweep_we", 32'(we), 1);
                chk("sweep_idx", 32'(idx), n);
                chk("sweep_x", 32'(wr_x), 32'(ex_x[n]));
                chk("sweep_y", 32'(wr_y), 32'(ex_y[n]));
            end
            if (n == tick_at) tick = 1'b1;
            step();
            tick = 1'b0;
            n++;
        end
        chk("sweep_len", n, 8);
        chk("post_we", 32'(we), 0);
        chk("post_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            chk("rf_x", 32'(rf_x[i]), 32'(ex_x[i]));
            chk("rf_y", 32'(rf_y[i]), 32'(ex_y[i]));
        end
    endtask

    task automatic no_sweep(input string tag, input logic [2:0] os, input logic [9:0] dy);
        outstate = os;
        doodle_y = dy;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk({tag, "_refresh"}, 32'(refresh), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_shift"}, 32'(shift), 0);
        chk({tag, "_total"}, 32'(total), exp_total);
        step();
        chk({tag, "_refresh2"}, 32'(refresh), 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; loadplat = 1'b0; outstate = 3'b000; doodle_y = 10'd300;
        s_tick = 1'b0; s_load = 1'b0; bd_en = 1'b0; bd_idx = 3'd0; bd_y = 10'd0;
        step();
        step();
        rst = 1'b0;
        chk("rst_refresh", 32'(refresh), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_total", 32'(total), 0);
        chk("rst_shift", 32'(shift), 0);
        chk("rst_wr", 32'({wr_x, wr_y}), 0);

        check_init();
        sweep(-1);

        bd_en = 1'b1; bd_idx = 3'd2; bd_y = 10'd476;
        step();
        bd_idx = 3'd5; bd_y = 10'd478;
        step();
        bd_en = 1'b0;
        resp_q.push_back(482);
        resp_q.push_back(365);
        sweep(3);

        no_sweep("at_line", 3'b001, 10'd160);
        no_sweep("pause", 3'b010, 10'd100);
        no_sweep("menu", 3'b000, 10'd100);

        outstate = 3'b001; doodle_y = 10'd100; tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step();
        chk("mid_refresh", 32'(refresh), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_total = 0;
        chk("abort_refresh", 32'(refresh), 0);
        chk("abort_we", 32'(we), 0);
        chk("abort_idx", 32'(idx), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_total", 32'(total), 0);

        check_init();
        sweep(-1);

        for (int k = 1; k <= 67; k++) begin
            s_tick = 1'b1;
            step();
            s_tick = 1'b0;
            if (k == 65) chk("sat_65000", 32'(s_total), 65000);
            if (k == 66) chk("sat_clip", 32'(s_total), 32'hFFFF);
            if (k == 67) chk("sat_hold", 32'(s_total), 32'hFFFF);
            repeat (8) step();
        end
        s_load = 1'b1;
        step();
        s_load = 1'b0;
        chk("sat_load_clr", 32'(s_total), 0);
        repeat (8) step();
        chk("sat_idle", 32'({s_busy, s_refresh, s_we, s_shift, s_idx}), 0);
        chk("sat_wr", 32'({s_wr_x, s_wr_y}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
